traffic_sensor_if: RTL and testbench
====================================

# traffic_sensor_if

Sensor front-end for the intersection controller. It conditions the raw E/W vehicle-loop detector and the raw emergency-preemption input into the clean `ew_sensor` and `emgcy_sensor` levels the controller consumes. It watches the controller's `ns_light`/`ew_light` outputs to latch and release E/W service requests, and it flags illegal light combinations. It sits between the detector pins and the controller's sensor inputs, in the controller's clock domain.

## Interface
- `DEBOUNCE`, 3: consecutive cycles a synchronized raw input must differ from its debounced value before the debounced value changes (legal 1..15).
- `EMGCY_HOLD`, 4: cycles `emgcy_sensor` stays high after debounced emergency falls (legal 0..15).
- `clk` in 1: master clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ew_loop_raw` in 1: raw E/W loop detector, asynchronous, may bounce.
- `emgcy_raw` in 1: raw emergency preemption, asynchronous, may bounce.
- `ns_light` in 3: controller N/S light. Encoding: OFF=0, RED=1, YELLOW=2, GREEN=3, PRE_GREEN=4.
- `ew_light` in 3: controller E/W light, same encoding.
- `ew_sensor` out 1: latched E/W service request to the controller.
- `emgcy_sensor` out 1: conditioned emergency request to the controller.
- `ew_wait_cycles` out 8: cycles the current E/W request has been pending; saturates at 255.
- `light_fault` out 1: sticky illegal-light flag.

## Operation
- **Synchronizers.** Each raw input passes through a 2-flop synchronizer (s1→s2), reset to 0.
- **Debounce.** Each input has its own 4-bit counter `cnt` and debounced bit `deb` (reset 0).
  - On an edge where s2 == deb: `cnt` ← 0.
  - On an edge where s2 != deb and `cnt` == DEBOUNCE-1: `deb` ← s2 and `cnt` ← 0.
  - On an edge where s2 != deb otherwise: `cnt` increments.
- **E/W request latch** (`ew_sensor`, registered). Conditions are evaluated each edge in this priority order:
  - `ew_light` == GREEN or OFF: clear.
  - loop `deb` == 1 and `ew_light` == RED: set.
  - otherwise: hold.
  - Consequences: a car that leaves after the request is set is still served. A car still present when E/W returns to RED re-requests.
- **Emergency.** `emgcy_sensor` ← emergency `deb` OR (`hold_cnt` != 0).
  - `hold_cnt` is loaded with EMGCY_HOLD on the edge where emergency `deb` falls 1→0.
  - It decrements to 0 while `deb` = 0.
  - It is forced to 0 while `deb` = 1, so re-assertion during the hold keeps the output continuously high.
  - With EMGCY_HOLD = 0 there is no extension.
- **Wait counter.** While `ew_sensor` = 1, `ew_wait_cycles` increments each edge, saturating at 255. On any edge where `ew_sensor` (current) = 0, it is set to 0.
- **Fault.** `light_fault` is set when either light code is 5..7, or when `ns_light` == GREEN and `ew_light` ∈ {GREEN, PRE_GREEN}.
  - It is set on the edge after the condition is seen.
  - It is sticky until reset.
  - It does not gate the other outputs.

## Timing
- **Reset.** Asynchronous assertion clears all state immediately: s1, s2, deb, cnt, hold_cnt, `ew_sensor`, `emgcy_sensor`, `ew_wait_cycles`, `light_fault` = 0. Release is synchronous to the next `clk` rise. Reset mid-request drops the request.
- **Rise latency.** Raw rises before edge 1 → s2 = 1 after edge 2 → deb = 1 after edge 1+DEBOUNCE+1 (edge 5 for DEBOUNCE=3) → output high after edge 6.
- **Fall latency.**
  - `ew_sensor` does not follow the raw input; only the light clears it.
  - `emgcy_sensor` falls after edge 6+EMGCY_HOLD from raw fall (edge 10 for the defaults).
- **Glitches.** A raw pulse whose s2 image lasts fewer than DEBOUNCE edges produces no output change; `cnt` restarts at 0.
- **Simultaneous events.**
  - Set and clear conditions in the same cycle cannot both hold (they are mutually exclusive by light value). Clear has priority by the ordering above.
  - The wait counter uses the pre-update `ew_sensor`, so it lags the request by one edge.

## Test plan
- **Clean rise.** `ew_light`=RED, `ew_loop_raw` 0→1 held → `ew_sensor`=1 after edge 6. Drive `ew_light`=GREEN → `ew_sensor`=0 on the next edge and `ew_wait_cycles`=0 one edge later.
- **Bounce rejection.** `ew_loop_raw` high for 2 cycles, low for 3, high for 2 (DEBOUNCE=3) → `ew_sensor` stays 0 throughout.
- **Emergency hold.** `emgcy_raw` high for 10 cycles, then low → `emgcy_sensor` high from edge 6 until it falls at edge 20 (raw fall at edge 10 + 6 + 4). A re-pulse of `emgcy_raw` during the hold → no low gap.
- **Wait saturation.** Hold a request with `ew_light`=RED for 300 cycles → `ew_wait_cycles` reaches 255 and stays. `ew_light`=OFF → clears to 0.
- **Fault.** Drive `ns_light`=GREEN, `ew_light`=PRE_GREEN for one cycle → `light_fault`=1, which stays 1 after the lights return to legal values. Code 7 on `ew_light` also sets the flag. `reset_n` low clears it immediately.
- **Mid-operation reset.** Assert `reset_n` low while `ew_sensor`=1 and `emgcy_sensor`=1 → both outputs 0 asynchronously. After release with raw inputs still high → both re-assert after edge 6.

Source files
------------

// File: rtl/traffic_sensor_if.sv
// Sensor front-end: synchronizes and debounces the E/W loop and emergency
// inputs, latches E/W service requests and flags illegal light combinations.
module traffic_sensor_if #(
    parameter int unsigned DEBOUNCE   = 3,
    parameter int unsigned EMGCY_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ew_loop_raw,
    input  logic       emgcy_raw,
    input  logic [2:0] ns_light,
    input  logic [2:0] ew_light,
    output logic       ew_sensor,
    output logic       emgcy_sensor,
    output logic [7:0] ew_wait_cycles,
    output logic       light_fault
);

    localparam logic [2:0] L_OFF   = 3'd0;
    localparam logic [2:0] L_RED   = 3'd1;
    localparam logic [2:0] L_GREEN = 3'd3;
    localparam logic [2:0] L_PRE   = 3'd4;

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [3:0] HOLD_INIT = 4'(EMGCY_HOLD);

    logic       loop_s1_q, loop_s1_d;
    logic       loop_s2_q, loop_s2_d;
    logic [3:0] loop_cnt_q, loop_cnt_d;
    logic       loop_deb_q, loop_deb_d;

    logic       em_s1_q, em_s1_d;
    logic       em_s2_q, em_s2_d;
    logic [3:0] em_cnt_q, em_cnt_d;
    logic       em_deb_q, em_deb_d;

    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       ew_sensor_q, ew_sensor_d;
    logic       emgcy_sensor_q, emgcy_sensor_d;
    logic [7:0] wait_q, wait_d;
    logic       fault_q, fault_d;

    logic       ew_clear;
    logic       ew_set;
    logic       code_bad;
    logic       green_clash;

    always_comb begin
        loop_s1_d  = ew_loop_raw;
        loop_s2_d  = loop_s1_q;
        loop_cnt_d = loop_cnt_q;
        loop_deb_d = loop_deb_q;
        if (loop_s2_q == loop_deb_q) begin
            loop_cnt_d = '0;
        end else if (loop_cnt_q == DEB_LAST) begin
            loop_deb_d = loop_s2_q;
            loop_cnt_d = '0;
        end else begin
            loop_cnt_d = loop_cnt_q + 4'd1;
        end
    end

    always_comb begin
        em_s1_d  = emgcy_raw;
        em_s2_d  = em_s1_q;
        em_cnt_d = em_cnt_q;
        em_deb_d = em_deb_q;
        if (em_s2_q == em_deb_q) begin
            em_cnt_d = '0;
        end else if (em_cnt_q == DEB_LAST) begin
            em_deb_d = em_s2_q;
            em_cnt_d = '0;
        end else begin
            em_cnt_d = em_cnt_q + 4'd1;
        end
    end

    // Hold starts on the falling edge of the debounced level, so a quick
    // re-assertion overlaps the extension and leaves no gap.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (em_deb_q) begin
            hold_cnt_d = em_deb_d ? 4'd0 : HOLD_INIT;
        end else if (hold_cnt_q != 4'd0) begin
            hold_cnt_d = hold_cnt_q - 4'd1;
        end
        emgcy_sensor_d = em_deb_q | (hold_cnt_q != 4'd0);
    end

    always_comb begin
        ew_clear    = (ew_light == L_GREEN) || (ew_light == L_OFF);
        ew_set      = loop_deb_q && (ew_light == L_RED);
        ew_sensor_d = ew_sensor_q;
        if (ew_clear) begin
            ew_sensor_d = 1'b0;
        end else if (ew_set) begin
            ew_sensor_d = 1'b1;
        end
    end

    always_comb begin
        wait_d = '0;
        if (ew_sensor_q) begin
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        end
    end

    always_comb begin
        code_bad    = (ns_light > L_PRE) || (ew_light > L_PRE);
        green_clash = (ns_light == L_GREEN)
                   && ((ew_light == L_GREEN) || (ew_light == L_PRE));
        fault_d     = fault_q | code_bad | green_clash;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_s1_q      <= 1'b0;
            loop_s2_q      <= 1'b0;
            loop_cnt_q     <= '0;
            loop_deb_q     <= 1'b0;
            em_s1_q        <= 1'b0;
            em_s2_q        <= 1'b0;
            em_cnt_q       <= '0;
            em_deb_q       <= 1'b0;
            hold_cnt_q     <= '0;
            ew_sensor_q    <= 1'b0;
            emgcy_sensor_q <= 1'b0;
            wait_q         <= '0;
            fault_q        <= 1'b0;
        end else begin
            loop_s1_q      <= loop_s1_d;
            loop_s2_q      <= loop_s2_d;
            loop_cnt_q     <= loop_cnt_d;
            loop_deb_q     <= loop_deb_d;
            em_s1_q        <= em_s1_d;
            em_s2_q        <= em_s2_d;
            em_cnt_q       <= em_cnt_d;
            em_deb_q       <= em_deb_d;
            hold_cnt_q     <= hold_cnt_d;
            ew_sensor_q    <= ew_sensor_d;
            emgcy_sensor_q <= emgcy_sensor_d;
            wait_q         <= wait_d;
            fault_q        <= fault_d;
        end
    end

    assign ew_sensor      = ew_sensor_q;
    assign emgcy_sensor   = emgcy_sensor_q;
    assign ew_wait_cycles = wait_q;
    assign light_fault    = fault_q;

endmodule

// File: tb/tb_traffic_sensor_if.sv
// Bench for traffic_sensor_if: vector table plus hand sequences, checked
// through an expected-value queue drained on the falling clock edge.
module tb_traffic_sensor_if;

    localparam logic [2:0] OFF = 3'd0;
    localparam logic [2:0] RED = 3'd1;
    localparam logic [2:0] YEL = 3'd2;
    localparam logic [2:0] GRN = 3'd3;
    localparam logic [2:0] PRE = 3'd4;
    localparam logic [2:0] BAD = 3'd7;

    typedef struct {
        bit         loop;
        bit         em;
        logic [2:0] ns;
        logic [2:0] ew;
        int         n;
        bit         ews;
        bit         emo;
        int         wt;
        int         flt;
    } vec_t;

    typedef struct {
        int due;
        int id;
        bit ews;
        bit emo;
        int wt;
        int flt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       ew_loop_raw = 1'b0;
    logic       emgcy_raw = 1'b0;
    logic [2:0] ns_light = RED;
    logic [2:0] ew_light = RED;
    logic       ew_sensor;
    logic       emgcy_sensor;
    logic [7:0] ew_wait_cycles;
    logic       light_fault;

    vec_t tbl [36];
    exp_t sb [$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    traffic_sensor_if #(
        .DEBOUNCE  (3),
        .EMGCY_HOLD(4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ew_loop_raw   (ew_loop_raw),
        .emgcy_raw     (emgcy_raw),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .ew_sensor     (ew_sensor),
        .emgcy_sensor  (emgcy_sensor),
        .ew_wait_cycles(ew_wait_cycles),
        .light_fault   (light_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(int id, string what, int act, int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %0d.%s: got %0d, expected %0d", id, what, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk(e.id, "ew_sensor", int'(ew_sensor), int'(e.ews));
            chk(e.id, "emgcy_sensor", int'(emgcy_sensor), int'(e.emo));
            if (e.wt >= 0) chk(e.id, "ew_wait_cycles", int'(ew_wait_cycles), e.wt);
            if (e.flt >= 0) chk(e.id, "light_fault", int'(light_fault), e.flt);
        end
    end

    task automatic apply(input int i);
        ew_loop_raw = tbl[i].loop;
        emgcy_raw   = tbl[i].em;
        ns_light    = tbl[i].ns;
        ew_light    = tbl[i].ew;
        sb.push_back('{cyc + tbl[i].n, i, tbl[i].ews, tbl[i].emo,
                       tbl[i].wt, tbl[i].flt});
        repeat (tbl[i].n) @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    task automatic check_cleared(input int id);
        chk(id, "rst.ew_sensor", int'(ew_sensor), 0);
        chk(id, "rst.emgcy_sensor", int'(emgcy_sensor), 0);
        chk(id, "rst.ew_wait_cycles", int'(ew_wait_cycles), 0);
        chk(id, "rst.light_fault", int'(light_fault), 0);
    endtask

    task automatic pulse_reset(input int id);
        #2 reset_n = 1'b0;
        #1 check_cleared(id);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0, 0, RED, RED, 2,   0, 0, 0,   0};
        tbl[1]  = '{1, 0, RED, RED, 5,   0, 0, 0,   0};
        tbl[2]  = '{1, 0, RED, RED, 1,   1, 0, 0,   0};
        tbl[3]  = '{1, 0, RED, RED, 1,   1, 0, 1,  -1};
        tbl[4]  = '{0, 0, RED, RED, 3,   1, 0, 4,  -1};
        tbl[5]  = '{0, 0, RED, GRN, 1,   0, 0, 5,  -1};
        tbl[6]  = '{0, 0, RED, GRN, 1,   0, 0, 0,  -1};
        tbl[7]  = '{1, 0, RED, GRN, 8,   0, 0, 0,  -1};
        tbl[8]  = '{1, 0, RED, YEL, 1,   0, 0, 0,  -1};
        tbl[9]  = '{1, 0, RED, RED, 1,   1, 0, 0,  -1};
        tbl[10] = '{0, 0, RED, OFF, 6,   0, 0, 0,  -1};
        tbl[11] = '{1, 0, RED, RED, 2,   0, 0, 0,  -1};
        tbl[12] = '{0, 0, RED, RED, 3,   0, 0, 0,  -1};
        tbl[13] = '{1, 0, RED, RED, 2,   0, 0, 0,  -1};
        tbl[14] = '{0, 0, RED, RED, 6,   0, 0, 0,   0};
        tbl[15] = '{0, 1, RED, RED, 5,   0, 0, 0,  -1};
        tbl[16] = '{0, 1, RED, RED, 1,   0, 1, 0,  -1};
        tbl[17] = '{0, 1, RED, RED, 4,   0, 1, 0,  -1};
        tbl[18] = '{0, 0, RED, RED, 9,   0, 1, 0,  -1};
        tbl[19] = '{0, 0, RED, RED, 1,   0, 0, 0,  -1};
        tbl[20] = '{0, 0, RED, RED, 2,   0, 0, 0,  -1};
        tbl[21] = '{0, 0, GRN, RED, 2,   0, 0, 0,   0};
        tbl[22] = '{0, 0, PRE, YEL, 1,   0, 0, 0,   0};
        tbl[23] = '{0, 0, GRN, YEL, 1,   0, 0, 0,   0};
        tbl[24] = '{1, 0, RED, RED, 260, 1, 0, 254, 0};
        tbl[25] = '{1, 0, RED, RED, 1,   1, 0, 255, 0};
        tbl[26] = '{1, 0, RED, RED, 39,  1, 0, 255, 0};
        tbl[27] = '{0, 0, RED, OFF, 1,   0, 0, 255, 0};
        tbl[28] = '{0, 0, RED, OFF, 5,   0, 0, 0,   0};
        tbl[29] = '{0, 0, GRN, PRE, 1,   0, 0, 0,   1};
        tbl[30] = '{0, 0, RED, RED, 3,   0, 0, 0,   1};
        tbl[31] = '{0, 0, RED, BAD, 1,   0, 0, 0,   1};
        tbl[32] = '{1, 1, RED, RED, 6,   1, 1, 0,  -1};
        tbl[33] = '{1, 1, RED, RED, 5,   0, 0, 0,   0};
        tbl[34] = '{1, 1, RED, RED, 1,   1, 1, 0,   0};
        tbl[35] = '{1, 1, RED, RED, 1,   1, 1, 1,   0};

        #1 reset_n = 1'b0;
        #2 check_cleared(900);
        @(negedge clk);
        reset_n = 1'b1;

        run_rows(0, 28);

        // Emergency drops long enough to debounce low, then returns
        // inside the hold window: output must stay high with no gap.
        ew_loop_raw = 1'b0;
        ns_light    = RED;
        ew_light    = RED;
        for (int e = 1; e <= 40; e++) begin
            emgcy_raw = (e <= 8) || (e >= 13 && e <= 24);
            sb.push_back('{cyc + 1, 100 + e, 1'b0,
                           (e >= 6 && e <= 33), -1, -1});
            @(negedge clk);
        end

        run_rows(29, 30);
        pulse_reset(901);
        run_rows(31, 32);
        pulse_reset(902);
        run_rows(33, 35);

        repeat (2) @(negedge clk);
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
